// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default frame length, sample width,
// the complex sample type and the input-unit FSM state encoding.
package fft_pkg;

  localparam int FFT_N    = 64;
  localparam int SAMPLE_W = 32;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } in_state_t;

endpackage

// File: rtl/fft_half_buffer.sv
// Half-frame sample store: N/2 entries of {re, im}, synchronous write,
// combinational read. No reset; contents are only meaningful once written.
module fft_half_buffer #(
  parameter int N  = 64,
  parameter int W  = 32,
  parameter int AW = $clog2(N/2)
) (
  input  logic            clk,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [2*W-1:0]  i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [2*W-1:0]  o_rd_data
);

  logic [2*W-1:0] r_mem [N/2];

  // Store one sample per write strobe
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fft_input_unit.sv
// FFT input unit: buffers the first half of each N-point frame and then emits
// (x[k], x[k+N/2]) pairs, one per accepted second-half sample, 1 cycle later.
// Optional feature macro: FFT_INPUT_RESYNC_EN -- a frame_start accepted
// mid-frame restarts the frame from that sample and pulses frame_err.
// Input handshake: din_valid alone qualifies din_* and frame_start; there is
// no backpressure, the unit accepts every valid sample.
module fft_input_unit
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int W  = SAMPLE_W,
  localparam int AW = $clog2(N/2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din_re,
  input  logic [W-1:0]  din_im,
  input  logic          din_valid,
  input  logic          frame_start,
  output logic [W-1:0]  dout_first_re,
  output logic [W-1:0]  dout_first_im,
  output logic [W-1:0]  dout_second_re,
  output logic [W-1:0]  dout_second_im,
  output logic          dout_valid,
  output logic [AW-1:0] dout_index,
  output logic          frame_done,
`ifdef FFT_INPUT_RESYNC_EN
  output logic          frame_err,
`endif
  output in_state_t     dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(N/2-1);

`ifdef FFT_INPUT_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  in_state_t      r_state, w_state_nxt;
  logic [AW-1:0]  r_idx, w_idx_nxt;
  logic           w_wr_en;
  logic [AW-1:0]  w_wr_addr;
  logic           w_emit;
  logic           w_abort;
  logic [2*W-1:0] w_rd_data;

  fft_half_buffer #(.N(N), .W(W), .AW(AW)) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data ({din_re, din_im}),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  // State and index register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: walk the frame, restarting on an abort
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (din_valid) begin
      if (frame_start && (r_state == IDLE || RESYNC)) begin
        w_state_nxt = FILL;
        w_idx_nxt   = AW'(1);
      end else begin
        case (r_state)
          FILL: begin
            if (r_idx == LAST) begin
              w_state_nxt = PAIR;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + AW'(1);
            end
          end
          PAIR: begin
            if (r_idx == LAST) begin
              w_state_nxt = IDLE;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + AW'(1);
            end
          end
          default: begin
            w_state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  // Per-cycle controls: buffer write, pair emission, abort detection
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_idx;
    w_emit    = 1'b0;
    w_abort   = 1'b0;
    if (din_valid) begin
      if (frame_start && (r_state == IDLE || RESYNC)) begin
        w_wr_en   = 1'b1;
        w_wr_addr = '0;
        w_abort   = (r_state != IDLE);
      end else if (r_state == FILL) begin
        w_wr_en = 1'b1;
      end else if (r_state == PAIR) begin
        w_emit = 1'b1;
      end
    end
  end

  // Registered outputs; pair data holds between emissions
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_first_re  <= '0;
      dout_first_im  <= '0;
      dout_second_re <= '0;
      dout_second_im <= '0;
      dout_valid     <= 1'b0;
      dout_index     <= '0;
      frame_done     <= 1'b0;
    end else begin
      dout_valid <= w_emit;
      frame_done <= w_emit && (r_idx == LAST);
      if (w_emit) begin
        dout_first_re  <= w_rd_data[2*W-1:W];
        dout_first_im  <= w_rd_data[W-1:0];
        dout_second_re <= din_re;
        dout_second_im <= din_im;
        dout_index     <= r_idx;
      end
    end
  end

`ifdef FFT_INPUT_RESYNC_EN
  // Mid-frame restart indicator
  always_ff @(posedge clk) begin
    if (!rst) frame_err <= 1'b0;
    else      frame_err <= w_abort;
  end
`else
  logic w_unused_abort;
  assign w_unused_abort = w_abort;
`endif

  assign dbg_state = r_state;

endmodule

// File: tb/tb_fft_input_unit.sv
// Bench for fft_input_unit at N=8: directed frames, a per-cycle comparison
// against a frame-position model, and literal pair lists for each scenario.
module tb_fft_input_unit;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int H  = N / 2;
  localparam int W  = 32;
  localparam int AW = 2;

`ifdef FFT_INPUT_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  din_re = '0, din_im = '0;
  logic          din_valid = 1'b0, frame_start = 1'b0;
  logic [W-1:0]  dout_first_re, dout_first_im, dout_second_re, dout_second_im;
  logic          dout_valid, frame_done;
  logic [AW-1:0] dout_index;
  logic          frame_err_w;
  in_state_t     dbg_state;

  fft_input_unit #(.N(N), .W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .din_re         (din_re),
    .din_im         (din_im),
    .din_valid      (din_valid),
    .frame_start    (frame_start),
    .dout_first_re  (dout_first_re),
    .dout_first_im  (dout_first_im),
    .dout_second_re (dout_second_re),
    .dout_second_im (dout_second_im),
    .dout_valid     (dout_valid),
    .dout_index     (dout_index),
    .frame_done     (frame_done),
`ifdef FFT_INPUT_RESYNC_EN
    .frame_err      (frame_err_w),
`endif
    .dbg_state      (dbg_state)
  );

`ifndef FFT_INPUT_RESYNC_EN
  assign frame_err_w = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: position of each accepted sample within its frame
  bit          m_in_frame = 1'b0;
  int          m_pos = 0;
  logic [W-1:0] m_re [N];
  logic [W-1:0] m_im [N];
  logic [W-1:0] e_first_re = '0, e_first_im = '0, e_second_re = '0, e_second_im = '0;
  logic         e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0;
  int           e_index = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_in_frame = 1'b0; m_pos = 0;
      e_first_re = '0; e_first_im = '0; e_second_re = '0; e_second_im = '0;
      e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0; e_index = 0;
    end else begin
      e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (din_valid) begin
        if (frame_start && (!m_in_frame || RESYNC)) begin
          e_err = m_in_frame;
          m_in_frame = 1'b1;
          m_pos = 0;
        end
        if (m_in_frame) begin
          m_re[m_pos] = din_re;
          m_im[m_pos] = din_im;
          if (m_pos >= H) begin
            e_valid     = 1'b1;
            e_index     = m_pos - H;
            e_first_re  = m_re[m_pos - H];
            e_first_im  = m_im[m_pos - H];
            e_second_re = din_re;
            e_second_im = din_im;
            e_done      = (m_pos == N - 1);
          end
          m_pos++;
          if (m_pos == N) begin
            m_in_frame = 1'b0;
            m_pos = 0;
          end
        end
      end
    end
  end

  // scoreboard: observed pairs, checked against literal expectations
  typedef struct {
    int first_re; int first_im; int second_re; int second_im; int index; bit done;
  } pair_t;
  pair_t pair_log[$];
  logic [W-1:0] exp_q[$];

  // compare process: every cycle after reset release
  always @(negedge clk) begin
    if (started) begin
      chk("dout_valid", 64'(dout_valid), 64'(e_valid));
      chk("frame_done", 64'(frame_done), 64'(e_done));
      chk("frame_err", 64'(frame_err_w), 64'(e_err));
      chk("dout_index", 64'(dout_index), 64'(e_index));
      chk("dout_first_re", 64'(dout_first_re), 64'(e_first_re));
      chk("dout_first_im", 64'(dout_first_im), 64'(e_first_im));
      chk("dout_second_re", 64'(dout_second_re), 64'(e_second_re));
      chk("dout_second_im", 64'(dout_second_im), 64'(e_second_im));
      if (dout_valid === 1'b1)
        pair_log.push_back('{int'(dout_first_re), int'(dout_first_im), int'(dout_second_re),
                             int'(dout_second_im), int'(dout_index), frame_done});
    end
  end

  // driver tasks
  task automatic send(input int v, input bit fs);
    @(negedge clk);
    din_valid   = 1'b1;
    frame_start = fs;
    din_re      = W'(v);
    din_im      = W'(-v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid   = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < N; i++) begin
      send(base + i, i == 0);
      if (gaps) idle(1);
    end
  endtask

  task automatic expect_pair(input int f, input int s, input int k);
    exp_q.push_back(W'(f));
    exp_q.push_back(W'(s));
    exp_q.push_back(W'(k));
  endtask

  // compare logged pairs with queued literal expectations
  task automatic check_log(input string name);
    int n;
    n = exp_q.size() / 3;
    chk({name, "_pair_count"}, 64'(pair_log.size()), 64'(n));
    for (int i = 0; i < n && i < pair_log.size(); i++) begin
      logic [W-1:0] f, s, k;
      f = exp_q.pop_front();
      s = exp_q.pop_front();
      k = exp_q.pop_front();
      chk({name, "_first_re"}, 64'(pair_log[i].first_re), 64'(f));
      chk({name, "_first_im"}, 64'(W'(pair_log[i].first_im)), 64'(W'(-int'(f))));
      chk({name, "_second_re"}, 64'(pair_log[i].second_re), 64'(s));
      chk({name, "_second_im"}, 64'(W'(pair_log[i].second_im)), 64'(W'(-int'(s))));
      chk({name, "_index"}, 64'(pair_log[i].index), 64'(k));
      chk({name, "_done"}, 64'(pair_log[i].done), 64'(k == W'(H - 1)));
    end
    exp_q.delete();
    pair_log.delete();
  endtask

  initial begin
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_valid", 64'(dout_valid), 64'd0);
    chk("reset_first_re", 64'(dout_first_re), 64'd0);
    chk("reset_index", 64'(dout_index), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    started = 1'b1;

    // 1: plain frame
    send_frame(1, 1'b0); idle(2);
    for (int k = 0; k < H; k++) expect_pair(1 + k, 5 + k, k);
    check_log("t1");

    // 2: same frame with a gap after every sample
    send_frame(1, 1'b1); idle(2);
    for (int k = 0; k < H; k++) expect_pair(1 + k, 5 + k, k);
    check_log("t2");

    // 3: back-to-back frames
    send_frame(10, 1'b0); send_frame(20, 1'b0); idle(2);
    for (int k = 0; k < H; k++) expect_pair(10 + k, 14 + k, k);
    for (int k = 0; k < H; k++) expect_pair(20 + k, 24 + k, k);
    check_log("t3");

    // 4: leading samples without frame_start are dropped
    send(90, 1'b0); send(91, 1'b0); send(92, 1'b0);
    send_frame(1, 1'b0); idle(2);
    for (int k = 0; k < H; k++) expect_pair(1 + k, 5 + k, k);
    check_log("t4");

    // 5: reset during PAIR after pair k=1, then a fresh frame
    for (int i = 0; i < 6; i++) send(1 + i, i == 0);
    @(negedge clk);
    din_valid = 1'b0; frame_start = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_rst_valid", 64'(dout_valid), 64'd0);
    chk("t5_rst_first_re", 64'(dout_first_re), 64'd0);
    chk("t5_rst_second_re", 64'(dout_second_re), 64'd0);
    expect_pair(1, 5, 0); expect_pair(2, 6, 1);
    check_log("t5a");
    send_frame(30, 1'b0); idle(2);
    for (int k = 0; k < H; k++) expect_pair(30 + k, 34 + k, k);
    check_log("t5b");

    // 6: frame_start on the fourth sample of a frame
    for (int i = 0; i < N; i++) send(40 + i, i == 0 || i == 3);
    send(48, 1'b0); send(49, 1'b0); send(50, 1'b0);
    idle(2);
    if (RESYNC) begin
      for (int k = 0; k < H; k++) expect_pair(43 + k, 47 + k, k);
    end else begin
      for (int k = 0; k < H; k++) expect_pair(40 + k, 44 + k, k);
    end
    check_log("t6");

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
